// File: rtl/sme_pkg.sv
// Shared types for the SME ALU sequencer: opcodes, ALU control bit positions
// and the sequencer state encoding.
package sme_pkg;

   typedef enum logic [3:0] {
      OP_XOR    = 4'h0,
      OP_AND    = 4'h1,
      OP_OR     = 4'h2,
      OP_XNOR   = 4'h3,
      OP_ANDN   = 4'h4,
      OP_ORN    = 4'h5,
      OP_SLL    = 4'h6,
      OP_SRL    = 4'h7,
      OP_ROR    = 4'h8,
      OP_ROL    = 4'h9,
      OP_ADD    = 4'hA,
      OP_SUB    = 4'hB,
      OP_MASK   = 4'hC,
      OP_UNMASK = 4'hD,
      OP_REMASK = 4'hE,
      OP_ILL    = 4'hF
   } sme_op_t;

   localparam int ALU_OP_W   = 13;
   localparam int ALU_XOR    = 0;
   localparam int ALU_AND    = 1;
   localparam int ALU_OR     = 2;
   localparam int ALU_NOTRS2 = 3;
   localparam int ALU_SHIFT  = 4;
   localparam int ALU_ROTATE = 5;
   localparam int ALU_LEFT   = 6;
   localparam int ALU_RIGHT  = 7;
   localparam int ALU_ADD    = 8;
   localparam int ALU_SUB    = 9;
   localparam int ALU_MASK   = 10;
   localparam int ALU_UNMASK = 11;
   localparam int ALU_REMASK = 12;

   // Watchdog counter width; TMO must fit in it.
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_EXEC = 2'd2,
      ST_WB   = 2'd3
   } sme_state_t;

endpackage

// File: rtl/sme_op_decode.sv
// Combinational opcode decoder: maps an SME opcode onto the ALU control
// vector and flags opcodes the ALU cannot execute.
module sme_op_decode
   import sme_pkg::*;
(
   input  logic [3:0]          op_i,
   output logic [ALU_OP_W-1:0] alu_op_o,
   output logic                illegal_o
);

   always_comb begin
      alu_op_o  = '0;
      illegal_o = 1'b0;
      case (sme_op_t'(op_i))
         OP_XOR:    alu_op_o[ALU_XOR] = 1'b1;
         OP_AND:    alu_op_o[ALU_AND] = 1'b1;
         OP_OR:     alu_op_o[ALU_OR]  = 1'b1;
         OP_XNOR: begin
            alu_op_o[ALU_XOR]    = 1'b1;
            alu_op_o[ALU_NOTRS2] = 1'b1;
         end
         OP_ANDN: begin
            alu_op_o[ALU_AND]    = 1'b1;
            alu_op_o[ALU_NOTRS2] = 1'b1;
         end
         OP_ORN: begin
            alu_op_o[ALU_OR]     = 1'b1;
            alu_op_o[ALU_NOTRS2] = 1'b1;
         end
         OP_SLL: begin
            alu_op_o[ALU_SHIFT] = 1'b1;
            alu_op_o[ALU_LEFT]  = 1'b1;
         end
         OP_SRL: begin
            alu_op_o[ALU_SHIFT] = 1'b1;
            alu_op_o[ALU_RIGHT] = 1'b1;
         end
         OP_ROR: begin
            alu_op_o[ALU_ROTATE] = 1'b1;
            alu_op_o[ALU_RIGHT]  = 1'b1;
         end
         OP_ROL: begin
            alu_op_o[ALU_ROTATE] = 1'b1;
            alu_op_o[ALU_LEFT]   = 1'b1;
         end
         OP_ADD:    alu_op_o[ALU_ADD]    = 1'b1;
         OP_SUB:    alu_op_o[ALU_SUB]    = 1'b1;
         OP_MASK:   alu_op_o[ALU_MASK]   = 1'b1;
         OP_UNMASK: alu_op_o[ALU_UNMASK] = 1'b1;
         OP_REMASK: alu_op_o[ALU_REMASK] = 1'b1;
         default:   illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/sme_alu_seq.sv
// Core-side sequencer for the masked SME ALU: register read, ALU request
// handshake with watchdog, share write-back, flush and illegal-op reporting.
module sme_alu_seq
   import sme_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SMAX = 4,
   parameter int NREG = 16,
   parameter int TMO  = 15,
   localparam int AW  = $clog2(NREG),
   localparam int SW  = SMAX * XLEN
) (
   input  logic                g_clk,
   input  logic                g_reset,
   input  logic                flush,

   input  logic                cpu_valid,
   output logic                cpu_ready,
   input  logic [3:0]          cpu_op,
   input  logic [AW-1:0]       cpu_rs1,
   input  logic [AW-1:0]       cpu_rs2,
   input  logic [AW-1:0]       cpu_rd,
   input  logic [4:0]          cpu_shamt,

   output logic                rf_ren,
   output logic [AW-1:0]       rf_raddr1,
   output logic [AW-1:0]       rf_raddr2,
   input  logic [SW-1:0]       rf_rdata1,
   input  logic [SW-1:0]       rf_rdata2,
   output logic                rf_wen,
   output logic [AW-1:0]       rf_waddr,
   output logic [SW-1:0]       rf_wdata,

   output logic                alu_valid,
   input  logic                alu_ready,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [4:0]          alu_shamt,
   output logic [SW-1:0]       alu_rs1,
   output logic [SW-1:0]       alu_rs2,
   input  logic [SW-1:0]       alu_rd,

   output logic                done,
   output logic                err
);

   localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);

   sme_state_t           state_q,  state_d;
   sme_op_t              op_q,     op_d;
   logic [ALU_OP_W-1:0]  alu_op_q, alu_op_d;
   logic [AW-1:0]        rd_q,     rd_d;
   logic [4:0]           shamt_q,  shamt_d;
   logic [SW-1:0]        opa_q,    opa_d;
   logic [SW-1:0]        opb_q,    opb_d;
   logic [SW-1:0]        res_q,    res_d;
   logic [CNT_W-1:0]     cnt_q,    cnt_d;
   logic                 err_q,    err_d;

   logic [ALU_OP_W-1:0]  dec_alu_op;
   logic                 dec_illegal;

   sme_op_decode u_dec (
      .op_i      (cpu_op),
      .alu_op_o  (dec_alu_op),
      .illegal_o (dec_illegal)
   );

   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_XOR;
         alu_op_q <= '0;
         rd_q     <= '0;
         shamt_q  <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         alu_op_q <= alu_op_d;
         rd_q     <= rd_d;
         shamt_q  <= shamt_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      alu_op_d  = alu_op_q;
      rd_d      = rd_q;
      shamt_d   = shamt_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      err_d     = 1'b0;
      cpu_ready = 1'b0;
      rf_ren    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cpu_ready = !flush;
            if (cpu_valid && !flush) begin
               if (dec_illegal) begin
                  err_d = 1'b1;
               end else begin
                  rf_ren   = 1'b1;
                  op_d     = sme_op_t'(cpu_op);
                  alu_op_d = dec_alu_op;
                  rd_d     = cpu_rd;
                  shamt_d  = cpu_shamt;
                  state_d  = ST_READ;
               end
            end
         end
         ST_READ: begin
            opa_d   = rf_rdata1;
            opb_d   = rf_rdata2;
            cnt_d   = '0;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            // A response in the last watchdog cycle still counts as success.
            if (alu_ready) begin
               res_d   = alu_rd;
               state_d = ST_WB;
            end else if (cnt_q == TMO_C) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WB: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (flush) begin
         state_d = ST_IDLE;
         err_d   = 1'b0;
      end

      if (g_reset) begin
         cpu_ready = 1'b0;
         rf_ren    = 1'b0;
      end
   end

   assign rf_raddr1 = cpu_rs1;
   assign rf_raddr2 = cpu_rs2;

   assign alu_valid = (state_q == ST_EXEC);
   assign alu_op    = alu_op_q;
   assign alu_shamt = shamt_q;
   assign alu_rs1   = opa_q;
   assign alu_rs2   = opb_q;

   // r0 is never written, but the instruction still retires.
   assign done     = (state_q == ST_WB);
   assign rf_wen   = (state_q == ST_WB) && (rd_q != '0);
   assign rf_waddr = rd_q;
   assign err      = err_q;

   generate
      for (genvar gi = 0; gi < SMAX; gi++) begin : g_wb_share
         if (gi == 0) begin : g_keep
            assign rf_wdata[gi*XLEN +: XLEN] = res_q[gi*XLEN +: XLEN];
         end else begin : g_unmask
            assign rf_wdata[gi*XLEN +: XLEN] =
               (op_q == OP_UNMASK) ? '0 : res_q[gi*XLEN +: XLEN];
         end
      end
   endgenerate

endmodule

// File: tb/tb_sme_alu_seq.sv
// Self-checking bench for sme_alu_seq: opcode table, timing/flush/reset
// corner sequences and random instructions against a register-file model.
module tb_sme_alu_seq;

   localparam int XLEN = 32;
   localparam int SMAX = 4;
   localparam int NREG = 16;
   localparam int TMO  = 15;
   localparam int AW   = 4;
   localparam int SW   = SMAX * XLEN;

   logic          g_clk = 1'b0;
   logic          g_reset = 1'b1;
   logic          flush = 1'b0;
   logic          cpu_valid = 1'b0;
   logic          cpu_ready;
   logic [3:0]    cpu_op = '0;
   logic [AW-1:0] cpu_rs1 = '0, cpu_rs2 = '0, cpu_rd = '0;
   logic [4:0]    cpu_shamt = '0;
   logic          rf_ren;
   logic [AW-1:0] rf_raddr1, rf_raddr2;
   logic [SW-1:0] rf_rdata1, rf_rdata2;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [SW-1:0] rf_wdata;
   logic          alu_valid;
   logic          alu_ready;
   logic [12:0]   alu_op;
   logic [4:0]    alu_shamt;
   logic [SW-1:0] alu_rs1, alu_rs2, alu_rd;
   logic          done, err;

   sme_alu_seq #(.XLEN(XLEN), .SMAX(SMAX), .NREG(NREG), .TMO(TMO)) dut (
      .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
      .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_op(cpu_op),
      .cpu_rs1(cpu_rs1), .cpu_rs2(cpu_rs2), .cpu_rd(cpu_rd), .cpu_shamt(cpu_shamt),
      .rf_ren(rf_ren), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
      .alu_shamt(alu_shamt), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rd(alu_rd),
      .done(done), .err(err)
   );

   always #5 g_clk = ~g_clk;

   // Environment: register file with one-cycle read latency.
   logic [SW-1:0] env_rf [NREG];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_a = '0;
   logic [SW-1:0] pre_d = '0;
   always @(posedge g_clk) begin
      if (pre_we) env_rf[pre_a] <= pre_d;
      else if (rf_wen) env_rf[rf_waddr] <= rf_wdata;
      if (rf_ren) begin
         rf_rdata1 <= env_rf[rf_raddr1];
         rf_rdata2 <= env_rf[rf_raddr2];
      end
   end

   // Environment: ALU answers after alu_delay cycles of valid.
   int            vcnt;
   int            alu_delay = 0;
   logic          alu_force = 1'b0;
   logic [SW-1:0] alu_result = '0;
   always @(posedge g_clk) vcnt <= alu_valid ? vcnt + 1 : 0;
   assign alu_ready = alu_force | (alu_valid && (vcnt == alu_delay));
   assign alu_rd    = alu_result;

   // Reference register contents.
   logic [SW-1:0] ref_rf [NREG];
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string         tag;
      logic [3:0]    op;
      logic [AW-1:0] rs1, rs2, rd;
      logic [4:0]    sh;
      int            dly;
      logic [SW-1:0] res;
      logic [12:0]   xop;
   } vec_t;
   vec_t tbl [18];

   function automatic logic [12:0] exp_op_of(input logic [3:0] op);
      logic [12:0] t [16];
      t = '{13'h0001, 13'h0002, 13'h0004, 13'h0009, 13'h000A, 13'h000C,
            13'h0050, 13'h0090, 13'h00A0, 13'h0060, 13'h0100, 13'h0200,
            13'h0400, 13'h0800, 13'h1000, 13'h0000};
      return t[op];
   endfunction

   task automatic step();
      @(posedge g_clk);
      @(negedge g_clk);
   endtask

   task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_instr(input string tag, input logic [3:0] op,
                            input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic [AW-1:0] rd, input logic [4:0] sh,
                            input int dly, input logic [SW-1:0] res,
                            input logic [12:0] xop);
      logic          ill, tmo;
      logic [SW-1:0] a, b, w;
      int            nexec;
      ill   = (op == 4'hF);
      tmo   = (dly > TMO);
      nexec = tmo ? TMO + 1 : dly + 1;
      a = ref_rf[rs1];
      b = ref_rf[rs2];
      w = (op == 4'hD) ? {{(SW-XLEN){1'b0}}, res[XLEN-1:0]} : res;
      alu_delay  = dly;
      alu_result = res;
      $display("txn %-8s op=%h rs1=%0d rs2=%0d rd=%0d shamt=%0d alu_wait=%0d",
               tag, op, rs1, rs2, rd, sh, dly);
      cpu_valid = 1'b1; cpu_op = op; cpu_rs1 = rs1; cpu_rs2 = rs2;
      cpu_rd = rd; cpu_shamt = sh;
      #1;
      chk({tag, " accept_ready"}, cpu_ready, 1);
      chk({tag, " rf_ren"}, rf_ren, !ill);
      if (!ill) begin
         chk({tag, " raddr1"}, rf_raddr1, rs1);
         chk({tag, " raddr2"}, rf_raddr2, rs2);
      end
      step();
      cpu_valid = 1'b0;
      if (ill) begin
         chk({tag, " illegal_err"}, err, 1);
         chk({tag, " illegal_ready"}, cpu_ready, 1);
         chk({tag, " illegal_no_exec"}, alu_valid, 0);
         step();
         chk({tag, " illegal_err_pulse"}, err, 0);
      end else begin
         chk({tag, " read_valid"}, alu_valid, 0);
         chk({tag, " read_busy"}, cpu_ready, 0);
         for (int c = 0; c < nexec; c++) begin
            step();
            chk({tag, " exec_valid"}, alu_valid, 1);
            chk({tag, " exec_op"}, alu_op, xop);
            chk({tag, " exec_shamt"}, alu_shamt, sh);
            chk({tag, " exec_rs1"}, alu_rs1, a);
            chk({tag, " exec_rs2"}, alu_rs2, b);
            chk({tag, " exec_done"}, done, 0);
         end
         step();
         if (tmo) begin
            chk({tag, " tmo_err"}, err, 1);
            chk({tag, " tmo_valid"}, alu_valid, 0);
            chk({tag, " tmo_done"}, done, 0);
            chk({tag, " tmo_wen"}, rf_wen, 0);
         end else begin
            chk({tag, " wb_done"}, done, 1);
            chk({tag, " wb_wen"}, rf_wen, (rd != '0));
            chk({tag, " wb_err"}, err, 0);
            if (rd != '0) begin
               chk({tag, " wb_waddr"}, rf_waddr, rd);
               chk({tag, " wb_wdata"}, rf_wdata, w);
               ref_rf[rd] = w;
            end
         end
         step();
         chk({tag, " idle_ready"}, cpu_ready, 1);
         chk({tag, " idle_done"}, done, 0);
         chk({tag, " idle_err"}, err, 0);
      end
   endtask

   initial begin
      logic [3:0]    rop;
      logic [SW-1:0] rres;

      tbl[0]  = '{"xor",    4'h0, 4'd1, 4'd2, 4'd3,  5'd0,  0,
                  {32'h8, 32'h4, 32'h2, 32'h1}, 13'h0001};
      tbl[1]  = '{"add",    4'hA, 4'd3, 4'd1, 4'd4,  5'd0,  5,
                  {32'h0, 32'h0, 32'h0, 32'h12345678}, 13'h0100};
      tbl[2]  = '{"unmask", 4'hD, 4'd4, 4'd0, 4'd5,  5'd0,  0,
                  {32'h33, 32'h22, 32'h11, 32'hDEADBEEF}, 13'h0800};
      tbl[3]  = '{"and",    4'h1, 4'd1, 4'd5, 4'd6,  5'd0,  1,
                  {32'hA, 32'hB, 32'hC, 32'hD}, 13'h0002};
      tbl[4]  = '{"or",     4'h2, 4'd6, 4'd7, 4'd7,  5'd0,  2,
                  {32'h1, 32'h2, 32'h3, 32'h4}, 13'h0004};
      tbl[5]  = '{"xnor",   4'h3, 4'd7, 4'd7, 4'd8,  5'd0,  0,
                  {32'hF0, 32'hF1, 32'hF2, 32'hF3}, 13'h0009};
      tbl[6]  = '{"andn",   4'h4, 4'd8, 4'd3, 4'd9,  5'd0,  0,
                  {32'h5, 32'h6, 32'h7, 32'h8}, 13'h000A};
      tbl[7]  = '{"orn",    4'h5, 4'd9, 4'd8, 4'd10, 5'd0,  1,
                  {32'h9, 32'h9, 32'h9, 32'h9}, 13'h000C};
      tbl[8]  = '{"sll",    4'h6, 4'd10, 4'd0, 4'd11, 5'd7, 0,
                  {32'h100, 32'h200, 32'h300, 32'h400}, 13'h0050};
      tbl[9]  = '{"srl",    4'h7, 4'd11, 4'd0, 4'd12, 5'd31, 0,
                  {32'h1, 32'h0, 32'h0, 32'h1}, 13'h0090};
      tbl[10] = '{"ror",    4'h8, 4'd12, 4'd0, 4'd13, 5'd1, 3,
                  {32'h80000000, 32'h1, 32'h2, 32'h3}, 13'h00A0};
      tbl[11] = '{"rol",    4'h9, 4'd13, 4'd0, 4'd14, 5'd16, 0,
                  {32'hFFFF, 32'h0, 32'hFFFF, 32'h0}, 13'h0060};
      tbl[12] = '{"sub",    4'hB, 4'd14, 4'd13, 4'd15, 5'd0, 0,
                  {32'hCAFE, 32'hBABE, 32'hF00D, 32'hBEEF}, 13'h0200};
      tbl[13] = '{"mask",   4'hC, 4'd15, 4'd0, 4'd2,  5'd0,  0,
                  {32'h77, 32'h66, 32'h55, 32'h44}, 13'h0400};
      tbl[14] = '{"remask", 4'hE, 4'd2, 4'd0, 4'd2,  5'd0,  2,
                  {32'h13, 32'h57, 32'h9B, 32'hDF}, 13'h1000};
      tbl[15] = '{"illegal", 4'hF, 4'd1, 4'd2, 4'd3, 5'd0, 0,
                  {32'h0, 32'h0, 32'h0, 32'h0}, 13'h0000};
      tbl[16] = '{"last_ok", 4'hA, 4'd3, 4'd5, 4'd0, 5'd0, TMO,
                  {32'h1, 32'h1, 32'h1, 32'h1}, 13'h0100};
      tbl[17] = '{"timeout", 4'h0, 4'd1, 4'd2, 4'd6, 5'd3, 100,
                  {32'hE, 32'hE, 32'hE, 32'hE}, 13'h0001};

      // Preload while reset is held.
      @(negedge g_clk);
      for (int i = 0; i < NREG; i++) begin
         pre_we = 1'b1;
         pre_a  = AW'(i);
         if (i == 1)      pre_d = {32'h8, 32'h4, 32'h2, 32'h1};
         else if (i == 2) pre_d = '0;
         else             pre_d = {$urandom, $urandom, $urandom, $urandom};
         ref_rf[i] = pre_d;
         step();
      end
      pre_we = 1'b0;
      g_reset = 1'b0;
      #1;
      chk("reset cpu_ready", cpu_ready, 1);
      chk("reset alu_valid", alu_valid, 0);
      chk("reset rf_ren", rf_ren, 0);
      chk("reset rf_wen", rf_wen, 0);
      chk("reset done", done, 0);
      chk("reset err", err, 0);
      chk("reset alu_op", alu_op, 0);
      chk("reset alu_rs1", alu_rs1, 0);

      for (int i = 0; i < 18; i++)
         run_instr(tbl[i].tag, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                   tbl[i].sh, tbl[i].dly, tbl[i].res, tbl[i].xop);

      // Flush in the second EXEC cycle.
      $display("txn flush_exec op=a rd=7");
      alu_delay = 100;
      cpu_valid = 1'b1; cpu_op = 4'hA; cpu_rs1 = 4'd1; cpu_rs2 = 4'd1; cpu_rd = 4'd7;
      step();
      cpu_valid = 1'b0;
      step();
      step();
      chk("flush_exec pre_valid", alu_valid, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      chk("flush_exec valid", alu_valid, 0);
      chk("flush_exec done", done, 0);
      chk("flush_exec wen", rf_wen, 0);
      chk("flush_exec ready", cpu_ready, 1);
      run_instr("post_fl", 4'h0, 4'd1, 4'd2, 4'd8, 5'd0, 0,
                {32'h4, 32'h3, 32'h2, 32'h1}, 13'h0001);

      // Flush in IDLE beats an offered instruction.
      $display("txn flush_idle op=a rd=9");
      cpu_valid = 1'b1; cpu_op = 4'hA; cpu_rd = 4'd9; flush = 1'b1;
      #1;
      chk("flush_idle ready", cpu_ready, 0);
      chk("flush_idle ren", rf_ren, 0);
      step();
      cpu_valid = 1'b0; flush = 1'b0;
      #1;
      chk("flush_idle still_idle", cpu_ready, 1);
      step();
      chk("flush_idle no_exec", alu_valid, 0);

      // Reset mid-EXEC, then a late ALU response.
      $display("txn reset_exec op=b rd=10");
      alu_delay = 100;
      cpu_valid = 1'b1; cpu_op = 4'hB; cpu_rs1 = 4'd1; cpu_rs2 = 4'd3;
      cpu_rd = 4'd10; cpu_shamt = 5'd5;
      step();
      cpu_valid = 1'b0;
      step();
      step();
      chk("reset_exec pre_valid", alu_valid, 1);
      g_reset = 1'b1;
      step();
      g_reset = 1'b0;
      #1;
      chk("reset_exec valid", alu_valid, 0);
      chk("reset_exec ren", rf_ren, 0);
      chk("reset_exec wen", rf_wen, 0);
      chk("reset_exec done", done, 0);
      chk("reset_exec err", err, 0);
      chk("reset_exec alu_op", alu_op, 0);
      chk("reset_exec alu_rs1", alu_rs1, 0);
      chk("reset_exec alu_rs2", alu_rs2, 0);
      chk("reset_exec shamt", alu_shamt, 0);
      chk("reset_exec ready", cpu_ready, 1);
      alu_force = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("late_ready done", done, 0);
         chk("late_ready wen", rf_wen, 0);
         chk("late_ready valid", alu_valid, 0);
      end
      alu_force = 1'b0;
      step();

      // Random instruction stream.
      for (int i = 0; i < 40; i++) begin
         rop  = 4'($urandom_range(0, 15));
         rres = {$urandom, $urandom, $urandom, $urandom};
         run_instr("random", rop, AW'($urandom_range(0, NREG-1)),
                   AW'($urandom_range(0, NREG-1)), AW'($urandom_range(0, NREG-1)),
                   5'($urandom_range(0, 31)), $urandom_range(0, 3), rres,
                   exp_op_of(rop));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
